// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key map, row index type and small decode helpers.
// Used by the row scanner, the press FSM and the display logic.
package keypad_pkg;

    localparam int ROW_COUNT = 4;
    localparam int COL_COUNT = 4;

    typedef logic [1:0] row_idx_t;

    // Hex code of the key at [row][column index]
    localparam logic [3:0] KEYMAP [ROW_COUNT][COL_COUNT] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Active-low one-hot row drive pattern for a row index
    function automatic logic [3:0] row_drive(input row_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

    // True when exactly one column bit is set
    function automatic logic col_onehot(input logic [3:0] c);
        return (c != 4'b0000) && ((c & (c - 4'b0001)) == 4'b0000);
    endfunction

    // Index of the set bit of a one-hot column pattern
    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        case (c)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_scanner_col_debouncer.sv
// Column conditioning: two-flop synchroniser on the inverted raw columns,
// followed by a candidate/counter debouncer. clear restarts qualification
// (used when the scanner moves to a new row).
module col_debouncer #(
    parameter int DB_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] col_n,
    output logic [3:0] col
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_cand;
    logic [DB_W-1:0] r_db_cnt;
    logic [3:0]      r_col;

    assign col = r_col;

    // Two-flop synchroniser, converting to active-high on the way in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= ~col_n;
            r_sync2 <= r_sync1;
        end
    end

    // Candidate tracking: any change restarts the count, a full stable run publishes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cand   <= 4'b0000;
            r_db_cnt <= '0;
            r_col    <= 4'b0000;
        end else if (clear) begin
            r_cand   <= 4'b0000;
            r_db_cnt <= '0;
            r_col    <= 4'b0000;
        end else if (r_sync2 != r_cand) begin
            r_cand   <= r_sync2;
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_MAX) begin
            r_col    <= r_cand;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 keypad row scanner: walks an active-low row strobe, debounces the
// columns of the driven row and decodes the pressed key. enRow from the
// press FSM freezes the scan while a key is held.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 1024,
    parameter int DB_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enRow,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);

    logic [SC_W-1:0] r_scan_cnt;
    row_idx_t        r_row_idx;
    logic [3:0]      r_row_n;
    logic [3:0]      r_key;
    logic            r_key_valid;
    logic            w_advance;
    logic [3:0]      w_col;

    // Advance is decided from enRow as sampled on this edge
    assign w_advance = enRow && (r_scan_cnt == SC_MAX);

    assign row_n     = r_row_n;
    assign col       = w_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;

    col_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_col_debouncer (
        .clk   (clk),
        .reset (reset),
        .clear (w_advance),
        .col_n (col_n),
        .col   (w_col)
    );

    // Row timer and row drive; the drive register tracks the row index on every advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_row_idx  <= 2'd0;
            r_row_n    <= 4'b1110;
        end else if (w_advance) begin
            r_scan_cnt <= '0;
            r_row_idx  <= r_row_idx + 2'd1;
            r_row_n    <= row_drive(row_idx_t'(r_row_idx + 2'd1));
        end else if (enRow) begin
            r_scan_cnt <= r_scan_cnt + SC_W'(1);
        end else begin
            r_scan_cnt <= '0;
        end
    end

    // Key decode one cycle behind col; an ambiguous or empty pattern keeps the last key
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
        end else if (col_onehot(w_col)) begin
            r_key       <= KEYMAP[r_row_idx][col_index(w_col)];
            r_key_valid <= 1'b1;
        end else begin
            r_key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Self-checking bench for keypad_row_scanner: directed scenarios followed by
// randomized column/enable traffic, compared every cycle against a
// behavioural model of the scanner's rules.
module tb_keypad_row_scanner;

    localparam int SCAN_DIV  = 8;
    localparam int DB_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enRow;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Key map written out row by row: index = row*4 + column
    localparam logic [3:0] KMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Model state: synchroniser pipeline, recent effective samples, outputs
    logic [3:0] m_sync1, m_sync2, m_col, m_key;
    logic       m_valid;
    int         m_row, m_run;
    logic [3:0] m_win [$];

    always #5 clk = ~clk;

    keypad_row_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enRow     (enRow),
        .col_n     (col_n),
        .row_n     (row_n),
        .col       (col),
        .key       (key),
        .key_valid (key_valid)
    );

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 4'b0000;
        m_sync2 = 4'b0000;
        m_col   = 4'b0000;
        m_key   = 4'h0;
        m_valid = 1'b0;
        m_row   = 0;
        m_run   = 0;
        m_win.delete();
        m_win.push_back(4'b0000);
    endtask

    task automatic check_outputs();
        logic [3:0] exp_row;
        exp_row = 4'b0001 << m_row;
        check4("row_n", row_n, ~exp_row);
        check4("col", col, m_col);
        check4("key", key, m_key);
        check4("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
    endtask

    // One clock edge: predict from pre-edge inputs/state, then compare just after the edge
    task automatic tick();
        logic       en, nvalid, adv, same;
        logic [3:0] cn, ncol, nkey;
        int         nrow, nrun, cidx;
        en = enRow;
        cn = col_n;
        // key decode from the column pattern visible before this edge
        if ($countones(m_col) == 1) begin
            cidx = 0;
            for (int b = 0; b < 4; b++) if (m_col[b]) cidx = b;
            nkey   = KMAP[m_row * 4 + cidx];
            nvalid = 1'b1;
        end else begin
            nkey   = m_key;
            nvalid = 1'b0;
        end
        // a row lasts SCAN_DIV consecutive enabled edges
        adv  = en && (m_run + 1 == SCAN_DIV);
        nrun = (!en || adv) ? 0 : m_run + 1;
        nrow = adv ? (m_row + 1) % 4 : m_row;
        // col publishes a pattern once DB_CYCLES+1 consecutive effective samples agree
        ncol = m_col;
        if (adv) begin
            m_win.delete();
            m_win.push_back(4'b0000);
            ncol = 4'b0000;
        end else begin
            m_win.push_back(m_sync2);
            if (m_win.size() > DB_CYCLES + 1) void'(m_win.pop_front());
            if (m_win.size() == DB_CYCLES + 1) begin
                same = 1'b1;
                foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 1'b0;
                if (same) ncol = m_win[0];
            end
        end
        @(posedge clk);
        #1;
        m_sync2 = m_sync1;
        m_sync1 = ~cn;
        m_col   = ncol;
        m_key   = nkey;
        m_valid = nvalid;
        m_row   = nrow;
        m_run   = nrun;
        check_outputs();
    endtask

    initial begin
        int guard;
        int hold;
        int pick;
        reset = 1'b1;
        enRow = 1'b0;
        col_n = 4'b1111;
        model_reset();
        // asynchronous reset takes effect before any clock edge
        #1 reset = 1'b0;
        #1 check_outputs();
        repeat (3) @(posedge clk);
        #1 check_outputs();
        reset = 1'b1;

        // free scan with no key pressed
        enRow = 1'b1;
        repeat (40) tick();

        // stop on row 1 and press the key in column 1
        guard = 0;
        while (m_row != 1 && guard < 50) begin tick(); guard++; end
        check4("reach_row1", m_row[3:0], 4'd1);
        enRow = 1'b0;
        col_n = 4'b1101;
        repeat (10) tick();

        // bouncing contact never qualifies, then a steady press does
        for (int i = 0; i < 6; i++) begin
            col_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            repeat (2) tick();
        end
        col_n = 4'b1110;
        repeat (10) tick();

        // two columns at once on row 2
        col_n = 4'b1111;
        enRow = 1'b1;
        guard = 0;
        while (m_row != 2 && guard < 50) begin tick(); guard++; end
        check4("reach_row2", m_row[3:0], 4'd2);
        enRow = 1'b0;
        col_n = 4'b1010;
        repeat (10) tick();

        // key held across row advances
        enRow = 1'b1;
        col_n = 4'b1110;
        repeat (40) tick();

        // reset in the middle of a scan clears outputs without a clock
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        #1 check_outputs();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        reset = 1'b1;

        // randomized traffic
        for (int seg = 0; seg < 80; seg++) begin
            enRow = ($urandom_range(0, 3) != 0);
            pick  = $urandom_range(0, 2);
            case (pick)
                0:       col_n = 4'b1111;
                1:       col_n = ~(4'b0001 << $urandom_range(0, 3));
                default: col_n = 4'($urandom());
            endcase
            hold = $urandom_range(1, 14);
            repeat (hold) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
